// File: rtl/window_3x3_reader.sv
// window_3x3_reader: latches a 3-row set and streams its W-2 unpadded 3x3xK windows under valid/ready
module window_3x3_reader #(
  parameter int DATA_BITS = 8,
  parameter int W = 24,
  parameter int K = 6,
  parameter int COL_BITS = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic [W*DATA_BITS*K-1:0] row_1,
  input  logic [W*DATA_BITS*K-1:0] row_2,
  input  logic [W*DATA_BITS*K-1:0] row_3,
  input  logic valid_i,
  output logic row_ready,
  output logic win_valid,
  input  logic win_ready,
  output logic [9*K*DATA_BITS-1:0] win_data,
  output logic [COL_BITS-1:0] win_col,
  output logic win_last,
  output logic overflow
);
  localparam int RW = W*DATA_BITS*K;
  localparam int PW = K*DATA_BITS;
  localparam logic [COL_BITS-1:0] LAST = COL_BITS'(W-3);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;
  logic [RW-1:0] rows [3];
  logic [COL_BITS-1:0] col;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      col      <= '0;
      overflow <= 1'b0;
      rows[0]  <= '0;
      rows[1]  <= '0;
      rows[2]  <= '0;
    end else if (state == IDLE) begin
      if (valid_i) begin
        rows[0] <= row_1;
        rows[1] <= row_2;
        rows[2] <= row_3;
        col     <= '0;
        state   <= EMIT;
      end
    end else begin
      if (valid_i) overflow <= 1'b1;
      if (win_ready) begin
        col   <= (col == LAST) ? '0 : col + 1'b1;
        state <= (col == LAST) ? IDLE : EMIT;
      end
    end
  end
  assign row_ready = (state == IDLE);
  assign win_valid = (state == EMIT);
  assign win_last  = win_valid && (col == LAST);
  assign win_col   = col;
  // each window cell is one K-channel pixel slice taken from the latched rows
  for (genvar r = 0; r < 3; r++) begin : g_r
    for (genvar c = 0; c < 3; c++) begin : g_c
      assign win_data[(r*3+c)*PW +: PW] = rows[r][(32'(col)+c)*PW +: PW];
    end
  end
endmodule

// File: tb/tb_window_3x3_reader.sv
// tb_window_3x3_reader: scoreboarded checks of three window reader configurations
module tb_window_3x3_reader;
  typedef struct {logic [431:0] d; int col; bit last;} win_t;
  logic clk = 0;
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int cnt_a = 0, cnt_b = 0, cnt_c = 0, last_b = 0;
  win_t qa[$], qb[$], qc[$];
  // instance a: W=5 K=1
  logic ra = 1, a_v = 0, a_rr, a_wv, a_wr = 0, a_wl, a_ovf;
  logic [39:0] a_r1 = '0, a_r2 = '0, a_r3 = '0;
  logic [71:0] a_wd;
  logic [4:0] a_col;
  // instance b: W=24 K=6
  logic rb = 1, b_v = 0, b_rr, b_wv, b_wr = 0, b_wl, b_ovf;
  logic [1151:0] b_r1 = '0, b_r2 = '0, b_r3 = '0;
  logic [431:0] b_wd;
  logic [4:0] b_col;
  // instance c: W=3 K=2
  logic rc = 1, c_v = 0, c_rr, c_wv, c_wr = 0, c_wl, c_ovf;
  logic [47:0] c_r1 = '0, c_r2 = '0, c_r3 = '0;
  logic [143:0] c_wd;
  logic [1:0] c_col;

  window_3x3_reader #(.DATA_BITS(8), .W(5), .K(1), .COL_BITS(5)) dut_a (
    .clk(clk), .reset(ra), .row_1(a_r1), .row_2(a_r2), .row_3(a_r3), .valid_i(a_v),
    .row_ready(a_rr), .win_valid(a_wv), .win_ready(a_wr), .win_data(a_wd),
    .win_col(a_col), .win_last(a_wl), .overflow(a_ovf));
  window_3x3_reader #(.DATA_BITS(8), .W(24), .K(6), .COL_BITS(5)) dut_b (
    .clk(clk), .reset(rb), .row_1(b_r1), .row_2(b_r2), .row_3(b_r3), .valid_i(b_v),
    .row_ready(b_rr), .win_valid(b_wv), .win_ready(b_wr), .win_data(b_wd),
    .win_col(b_col), .win_last(b_wl), .overflow(b_ovf));
  window_3x3_reader #(.DATA_BITS(8), .W(3), .K(2), .COL_BITS(2)) dut_c (
    .clk(clk), .reset(rc), .row_1(c_r1), .row_2(c_r2), .row_3(c_r3), .valid_i(c_v),
    .row_ready(c_rr), .win_valid(c_wv), .win_ready(c_wr), .win_data(c_wd),
    .win_col(c_col), .win_last(c_wl), .overflow(c_ovf));

  function automatic logic [431:0] model(input logic [1151:0] r1, r2, r3, input int col, input int k);
    logic [1151:0] rr [3];
    logic [431:0] m = '0;
    rr[0] = r1; rr[1] = r2; rr[2] = r3;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        for (int ch = 0; ch < k; ch++)
          m[((r*3+c)*k+ch)*8 +: 8] = rr[r][((col+c)*k+ch)*8 +: 8];
    return m;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) if (!ra && a_wv && a_wr) begin
    win_t e;
    cnt_a++; n_cmp++;
    if (qa.size() == 0) begin
      n_bad++; $display("FAIL a_extra_window got col=%0d required none", a_col);
    end else begin
      e = qa.pop_front();
      if (a_wd !== e.d[71:0] || a_col !== 5'(e.col) || a_wl !== e.last) begin
        n_bad++;
        $display("FAIL a_window got col=%0d last=%0b data=%h required col=%0d last=%0b data=%h",
                 a_col, a_wl, a_wd, e.col, e.last, e.d[71:0]);
      end
    end
  end
  always @(negedge clk) if (!rb && b_wv && b_wr) begin
    win_t e;
    cnt_b++; n_cmp++;
    if (b_wl) last_b++;
    if (qb.size() == 0) begin
      n_bad++; $display("FAIL b_extra_window got col=%0d required none", b_col);
    end else begin
      e = qb.pop_front();
      if (b_wd !== e.d || b_col !== 5'(e.col) || b_wl !== e.last) begin
        n_bad++;
        $display("FAIL b_window got col=%0d last=%0b data=%h required col=%0d last=%0b data=%h",
                 b_col, b_wl, b_wd, e.col, e.last, e.d);
      end
    end
  end
  always @(negedge clk) if (!rc && c_wv && c_wr) begin
    win_t e;
    cnt_c++; n_cmp++;
    if (qc.size() == 0) begin
      n_bad++; $display("FAIL c_extra_window got col=%0d required none", c_col);
    end else begin
      e = qc.pop_front();
      if (c_wd !== e.d[143:0] || c_col !== 2'(e.col) || c_wl !== e.last) begin
        n_bad++;
        $display("FAIL c_window got col=%0d last=%0b data=%h required col=%0d last=%0b data=%h",
                 c_col, c_wl, c_wd, e.col, e.last, e.d[143:0]);
      end
    end
  end

  task automatic test_reset;
    ra = 1; rb = 1; rc = 1;
    tick; tick;
    ra = 0; rb = 0; rc = 0;
    n_cmp += 4;
    if ({b_rr, b_wv, b_wl, b_ovf} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_flags_b got %b required 1000", {b_rr, b_wv, b_wl, b_ovf});
    end
    if (b_wd !== '0 || b_col !== '0) begin
      n_bad++; $display("FAIL reset_data_b got col=%0d data=%h required 0", b_col, b_wd);
    end
    if ({a_rr, a_wv, a_wl, a_ovf, a_col} !== 9'b1000_00000 || a_wd !== '0) begin
      n_bad++; $display("FAIL reset_a got flags=%b col=%0d data=%h required 1000/0/0", {a_rr, a_wv, a_wl, a_ovf}, a_col, a_wd);
    end
    if ({c_rr, c_wv, c_wl, c_ovf} !== 4'b1000 || c_wd !== '0) begin
      n_bad++; $display("FAIL reset_c got flags=%b data=%h required 1000/0", {c_rr, c_wv, c_wl, c_ovf}, c_wd);
    end
  endtask

  task automatic load_a(input int base);
    for (int x = 0; x < 5; x++) begin
      a_r1[x*8 +: 8] = 8'(base + 16 + x);
      a_r2[x*8 +: 8] = 8'(base + 32 + x);
      a_r3[x*8 +: 8] = 8'(base + 48 + x);
    end
  endtask

  task automatic push_a;
    for (int c = 0; c < 3; c++) qa.push_back('{model(1152'(a_r1), 1152'(a_r2), 1152'(a_r3), c, 1), c, c == 2});
  endtask

  task automatic wait_a;
    for (int i = 0; i < 100 && !a_rr; i++) tick;
    n_cmp++;
    if (a_rr !== 1'b1) begin n_bad++; $display("FAIL a_timeout got row_ready=%b required 1", a_rr); end
  endtask

  task automatic test_basic;
    cnt_a = 0; load_a(0); push_a; a_wr = 1; a_v = 1;
    tick; a_v = 0;
    n_cmp++;
    if (a_wv !== 1'b1 || a_col !== 5'd0 || a_rr !== 1'b0) begin
      n_bad++; $display("FAIL basic_first got valid=%b col=%0d ready=%b required 1/0/0", a_wv, a_col, a_rr);
    end
    tick;
    n_cmp++;
    if (a_col !== 5'd1 || a_wl !== 1'b0 || a_wd !== 72'h333231232221131211) begin
      n_bad++; $display("FAIL basic_col1 got col=%0d last=%b data=%h required 1/0/333231232221131211", a_col, a_wl, a_wd);
    end
    tick;
    n_cmp++;
    if (a_col !== 5'd2 || a_wl !== 1'b1) begin
      n_bad++; $display("FAIL basic_last got col=%0d last=%b required 2/1", a_col, a_wl);
    end
    tick;
    n_cmp += 2;
    if (a_rr !== 1'b1 || a_wv !== 1'b0) begin
      n_bad++; $display("FAIL basic_idle got row_ready=%b valid=%b required 1/0", a_rr, a_wv);
    end
    if (cnt_a != 3 || qa.size() != 0) begin
      n_bad++; $display("FAIL basic_count got %0d left=%0d required 3/0", cnt_a, qa.size());
    end
  endtask

  task automatic test_back_pressure;
    logic [71:0] exp1;
    cnt_a = 0; load_a(64); push_a;
    exp1 = qa[1].d[71:0];
    a_wr = 1; a_v = 1;
    tick; a_v = 0;
    tick; a_wr = 0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (a_wv !== 1'b1 || a_col !== 5'd1 || a_wl !== 1'b0 || a_wd !== exp1) begin
        n_bad++; $display("FAIL stall_hold cycle %0d got valid=%b col=%0d data=%h required 1/1/%h", i, a_wv, a_col, a_wd, exp1);
      end
      tick;
    end
    a_wr = 1;
    tick;
    n_cmp++;
    if (a_col !== 5'd2 || a_wl !== 1'b1) begin
      n_bad++; $display("FAIL stall_resume got col=%0d last=%b required 2/1", a_col, a_wl);
    end
    wait_a;
    n_cmp++;
    if (cnt_a != 3 || qa.size() != 0) begin
      n_bad++; $display("FAIL stall_count got %0d left=%0d required 3/0", cnt_a, qa.size());
    end
  endtask

  task automatic test_overflow;
    cnt_a = 0; load_a(128); push_a; a_wr = 1; a_v = 1;
    tick; a_v = 0;
    load_a(5); a_v = 1;
    tick; a_v = 0;
    n_cmp++;
    if (a_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b required 1", a_ovf); end
    wait_a;
    push_a; a_v = 1;
    tick; a_v = 0;
    wait_a;
    n_cmp += 2;
    if (a_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b required 1", a_ovf); end
    if (cnt_a != 6 || qa.size() != 0) begin
      n_bad++; $display("FAIL ovf_count got %0d left=%0d required 6/0", cnt_a, qa.size());
    end
  endtask

  task automatic load_b;
    for (int i = 0; i < 36; i++) begin
      b_r1[i*32 +: 32] = $urandom; b_r2[i*32 +: 32] = $urandom; b_r3[i*32 +: 32] = $urandom;
    end
  endtask

  task automatic push_b;
    for (int c = 0; c < 22; c++) qb.push_back('{model(b_r1, b_r2, b_r3, c, 6), c, c == 21});
  endtask

  task automatic wait_b;
    for (int i = 0; i < 400 && !b_rr; i++) begin
      b_wr = ($urandom_range(0, 3) != 0);
      tick;
    end
    n_cmp++;
    if (b_rr !== 1'b1) begin n_bad++; $display("FAIL b_timeout got row_ready=%b required 1", b_rr); end
  endtask

  task automatic test_reset_mid_row;
    load_b; push_b; b_wr = 1; b_v = 1;
    tick; b_v = 0;
    load_b; b_v = 1;
    tick; b_v = 0;
    n_cmp++;
    if (b_col !== 5'd1 || b_ovf !== 1'b1) begin
      n_bad++; $display("FAIL midrst_setup got col=%0d ovf=%b required 1/1", b_col, b_ovf);
    end
    rb = 1;
    tick; rb = 0;
    n_cmp += 2;
    if ({b_rr, b_wv, b_wl, b_ovf} !== 4'b1000 || b_col !== '0) begin
      n_bad++; $display("FAIL midrst_flags got flags=%b col=%0d required 1000/0", {b_rr, b_wv, b_wl, b_ovf}, b_col);
    end
    if (b_wd !== '0) begin n_bad++; $display("FAIL midrst_data got %h required 0", b_wd); end
    qb.delete(); cnt_b = 0;
    load_b; push_b; b_wr = 1; b_v = 1;
    tick; b_v = 0;
    n_cmp++;
    if (b_wv !== 1'b1 || b_col !== 5'd0) begin
      n_bad++; $display("FAIL midrst_restart got valid=%b col=%0d required 1/0", b_wv, b_col);
    end
    b_wr = 1;
    for (int i = 0; i < 100 && !b_rr; i++) tick;
    n_cmp++;
    if (cnt_b != 22 || qb.size() != 0) begin
      n_bad++; $display("FAIL midrst_count got %0d left=%0d required 22/0", cnt_b, qb.size());
    end
  endtask

  task automatic test_multichannel;
    cnt_b = 0; last_b = 0;
    for (int s = 0; s < 4; s++) begin
      wait_b;
      load_b; push_b; b_v = 1; b_wr = $urandom_range(0, 1);
      tick; b_v = 0;
    end
    wait_b;
    n_cmp += 2;
    if (cnt_b != 88 || qb.size() != 0) begin
      n_bad++; $display("FAIL multi_count got %0d left=%0d required 88/0", cnt_b, qb.size());
    end
    if (last_b != 4) begin n_bad++; $display("FAIL multi_last got %0d required 4", last_b); end
  endtask

  task automatic test_degenerate;
    c_r1 = {$urandom, $urandom}; c_r2 = {$urandom, $urandom}; c_r3 = {$urandom, $urandom};
    qc.push_back('{model(1152'(c_r1), 1152'(c_r2), 1152'(c_r3), 0, 2), 0, 1'b1});
    cnt_c = 0; c_wr = 1; c_v = 1;
    tick; c_v = 0;
    n_cmp++;
    if (c_wv !== 1'b1 || c_wl !== 1'b1 || c_col !== 2'd0) begin
      n_bad++; $display("FAIL w3_window got valid=%b last=%b col=%0d required 1/1/0", c_wv, c_wl, c_col);
    end
    tick;
    n_cmp++;
    if (c_rr !== 1'b1 || c_wv !== 1'b0 || cnt_c != 1) begin
      n_bad++; $display("FAIL w3_idle got row_ready=%b valid=%b count=%0d required 1/0/1", c_rr, c_wv, cnt_c);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_pressure;
    test_overflow;
    test_reset_mid_row;
    test_multichannel;
    test_degenerate;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
